// File: rtl/lii_req_arbiter.sv
// rtl/lii_req_arbiter.sv - round-robin N:1 LII request arbiter with dst-routed response demux
//
// Request side: N_PORTS slave request streams are merged onto one master request link.
// Arbitration is round-robin and packet-locked: once a port is granted it owns the link
// until its tlast beat is accepted. One ARB cycle is spent between packets.
// Response side: flits from the shared response link are broadcast to all ports. tvalid
// is raised only on the port whose ID (PORT_ID_BASE+i) matches m_resp_dst. Flits with
// no matching port are accepted and counted as dropped.
//
// Ports
//   clk, rstn                         clock, synchronous active-low reset
//   s_req_*   (per port, sliced)      requester streams in, s_req_tready out
//   m_req_*                           shared request link out, m_req_tready in
//   m_resp_*                          shared response link in, m_resp_tready out
//   s_resp_*  (per port, broadcast)   response streams out, s_resp_tready in
//   grant_onehot                      registered grant, zero while arbitrating
//   pkt_cnt                           completed request packets (wrapping)
//   drop_cnt                          response beats dropped for unknown dst (wrapping)

module lii_req_arbiter #(
    parameter int         N_PORTS      = 4,
    parameter int         LII_DW       = 1024,
    parameter logic [7:0] PORT_ID_BASE = 8'h10
) (
    input  logic                          clk,
    input  logic                          rstn,

    input  logic [N_PORTS*LII_DW-1:0]     s_req_tdata,
    input  logic [N_PORTS*LII_DW/8-1:0]   s_req_tkeep,
    input  logic [N_PORTS*LII_DW/8-1:0]   s_req_tstrb,
    input  logic [N_PORTS*8-1:0]          s_req_src,
    input  logic [N_PORTS*8-1:0]          s_req_dst,
    input  logic [N_PORTS-1:0]            s_req_tlast,
    input  logic [N_PORTS-1:0]            s_req_tvalid,
    output logic [N_PORTS-1:0]            s_req_tready,

    output logic [LII_DW-1:0]             m_req_tdata,
    output logic [LII_DW/8-1:0]           m_req_tkeep,
    output logic [LII_DW/8-1:0]           m_req_tstrb,
    output logic                          m_req_tlast,
    output logic [7:0]                    m_req_src,
    output logic [7:0]                    m_req_dst,
    output logic                          m_req_tvalid,
    input  logic                          m_req_tready,

    input  logic [LII_DW-1:0]             m_resp_tdata,
    input  logic [LII_DW/8-1:0]           m_resp_tkeep,
    input  logic [LII_DW/8-1:0]           m_resp_tstrb,
    input  logic                          m_resp_tlast,
    input  logic [7:0]                    m_resp_src,
    input  logic [7:0]                    m_resp_dst,
    input  logic                          m_resp_tvalid,
    output logic                          m_resp_tready,

    output logic [N_PORTS*LII_DW-1:0]     s_resp_tdata,
    output logic [N_PORTS*LII_DW/8-1:0]   s_resp_tkeep,
    output logic [N_PORTS*LII_DW/8-1:0]   s_resp_tstrb,
    output logic [N_PORTS-1:0]            s_resp_tlast,
    output logic [N_PORTS*8-1:0]          s_resp_src,
    output logic [N_PORTS*8-1:0]          s_resp_dst,
    output logic [N_PORTS-1:0]            s_resp_tvalid,
    input  logic [N_PORTS-1:0]            s_resp_tready,

    output logic [N_PORTS-1:0]            grant_onehot,
    output logic [15:0]                   pkt_cnt,
    output logic [15:0]                   drop_cnt
);

    localparam int KW = LII_DW / 8;
    localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [IW-1:0]       gidx, gidx_nxt;
    logic [IW-1:0]       last, last_nxt;
    logic [N_PORTS-1:0]  grant_nxt;
    logic                pkt_done;

    logic                win_found;
    logic [IW-1:0]       win_idx;

    logic [N_PORTS-1:0]  resp_match;
    logic                resp_any;
    logic                resp_drop;

    // (base + step) mod N_PORTS, with step in 1..N_PORTS
    function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] base, input int step);
        int c;
        c = int'(base) + step;
        if (c >= N_PORTS) begin
            c = c - N_PORTS;
        end
        return IW'(c);
    endfunction

    // Round-robin search starting after the last granted port. Scanning from the
    // farthest candidate down lets the nearest valid port overwrite the result.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = N_PORTS; k >= 1; k--) begin
            if (s_req_tvalid[rr_next(last, k)]) begin
                win_found = 1'b1;
                win_idx   = rr_next(last, k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= ARB;
            gidx         <= '0;
            grant_onehot <= '0;
            last         <= IW'(N_PORTS - 1);
            pkt_cnt      <= '0;
            drop_cnt     <= '0;
        end else begin
            state        <= state_nxt;
            gidx         <= gidx_nxt;
            grant_onehot <= grant_nxt;
            last         <= last_nxt;
            if (pkt_done) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
            if (resp_drop) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gidx_nxt  = gidx;
        grant_nxt = grant_onehot;
        last_nxt  = last;
        pkt_done  = 1'b0;
        case (state)
            ARB: begin
                if (win_found) begin
                    state_nxt = LOCK;
                    gidx_nxt  = win_idx;
                    grant_nxt = N_PORTS'(1) << win_idx;
                end
            end
            LOCK: begin
                // Only the tlast handshake releases the lock; a stalled or idle
                // granted port keeps ownership.
                if (m_req_tvalid && m_req_tready && m_req_tlast) begin
                    state_nxt = ARB;
                    last_nxt  = gidx;
                    grant_nxt = '0;
                    pkt_done  = 1'b1;
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    // Request mux: data fields follow gidx at all times, tvalid/tready only in LOCK.
    always_comb begin
        m_req_tdata  = s_req_tdata[int'(gidx)*LII_DW +: LII_DW];
        m_req_tkeep  = s_req_tkeep[int'(gidx)*KW +: KW];
        m_req_tstrb  = s_req_tstrb[int'(gidx)*KW +: KW];
        m_req_src    = s_req_src[int'(gidx)*8 +: 8];
        m_req_dst    = s_req_dst[int'(gidx)*8 +: 8];
        m_req_tlast  = s_req_tlast[gidx];
        m_req_tvalid = (state == LOCK) && s_req_tvalid[gidx];
        s_req_tready = '0;
        if (state == LOCK) begin
            s_req_tready[gidx] = m_req_tready;
        end
    end

    // Response demux, independent of the request FSM.
    always_comb begin
        resp_match = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            resp_match[i] = (m_resp_dst == PORT_ID_BASE + 8'(i));
        end
    end

    assign resp_any      = |resp_match;
    assign s_resp_tvalid = resp_match & {N_PORTS{m_resp_tvalid}};
    // Unknown destinations are sunk so a stray flit cannot block the link.
    assign m_resp_tready = resp_any ? |(resp_match & s_resp_tready) : 1'b1;
    assign resp_drop     = m_resp_tvalid && !resp_any;

    assign s_resp_tdata  = {N_PORTS{m_resp_tdata}};
    assign s_resp_tkeep  = {N_PORTS{m_resp_tkeep}};
    assign s_resp_tstrb  = {N_PORTS{m_resp_tstrb}};
    assign s_resp_tlast  = {N_PORTS{m_resp_tlast}};
    assign s_resp_src    = {N_PORTS{m_resp_src}};
    assign s_resp_dst    = {N_PORTS{m_resp_dst}};

endmodule

// File: tb/tb_lii_req_arbiter.sv
// tb/tb_lii_req_arbiter.sv - scoreboard testbench for lii_req_arbiter
module tb_lii_req_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int KW = DW / 8;

    logic                 clk;
    logic                 rstn;
    logic [NP*DW-1:0]     s_req_tdata;
    logic [NP*KW-1:0]     s_req_tkeep;
    logic [NP*KW-1:0]     s_req_tstrb;
    logic [NP*8-1:0]      s_req_src;
    logic [NP*8-1:0]      s_req_dst;
    logic [NP-1:0]        s_req_tlast;
    logic [NP-1:0]        s_req_tvalid;
    logic [NP-1:0]        s_req_tready;
    logic [DW-1:0]        m_req_tdata;
    logic [KW-1:0]        m_req_tkeep;
    logic [KW-1:0]        m_req_tstrb;
    logic                 m_req_tlast;
    logic [7:0]           m_req_src;
    logic [7:0]           m_req_dst;
    logic                 m_req_tvalid;
    logic                 m_req_tready;
    logic [DW-1:0]        m_resp_tdata;
    logic [KW-1:0]        m_resp_tkeep;
    logic [KW-1:0]        m_resp_tstrb;
    logic                 m_resp_tlast;
    logic [7:0]           m_resp_src;
    logic [7:0]           m_resp_dst;
    logic                 m_resp_tvalid;
    logic                 m_resp_tready;
    logic [NP*DW-1:0]     s_resp_tdata;
    logic [NP*KW-1:0]     s_resp_tkeep;
    logic [NP*KW-1:0]     s_resp_tstrb;
    logic [NP-1:0]        s_resp_tlast;
    logic [NP*8-1:0]      s_resp_src;
    logic [NP*8-1:0]      s_resp_dst;
    logic [NP-1:0]        s_resp_tvalid;
    logic [NP-1:0]        s_resp_tready;
    logic [NP-1:0]        grant_onehot;
    logic [15:0]          pkt_cnt;
    logic [15:0]          drop_cnt;

    lii_req_arbiter #(.N_PORTS(NP), .LII_DW(DW), .PORT_ID_BASE(8'h10)) dut (
        .clk(clk), .rstn(rstn),
        .s_req_tdata(s_req_tdata), .s_req_tkeep(s_req_tkeep), .s_req_tstrb(s_req_tstrb),
        .s_req_src(s_req_src), .s_req_dst(s_req_dst), .s_req_tlast(s_req_tlast),
        .s_req_tvalid(s_req_tvalid), .s_req_tready(s_req_tready),
        .m_req_tdata(m_req_tdata), .m_req_tkeep(m_req_tkeep), .m_req_tstrb(m_req_tstrb),
        .m_req_tlast(m_req_tlast), .m_req_src(m_req_src), .m_req_dst(m_req_dst),
        .m_req_tvalid(m_req_tvalid), .m_req_tready(m_req_tready),
        .m_resp_tdata(m_resp_tdata), .m_resp_tkeep(m_resp_tkeep), .m_resp_tstrb(m_resp_tstrb),
        .m_resp_tlast(m_resp_tlast), .m_resp_src(m_resp_src), .m_resp_dst(m_resp_dst),
        .m_resp_tvalid(m_resp_tvalid), .m_resp_tready(m_resp_tready),
        .s_resp_tdata(s_resp_tdata), .s_resp_tkeep(s_resp_tkeep), .s_resp_tstrb(s_resp_tstrb),
        .s_resp_tlast(s_resp_tlast), .s_resp_src(s_resp_src), .s_resp_dst(s_resp_dst),
        .s_resp_tvalid(s_resp_tvalid), .s_resp_tready(s_resp_tready),
        .grant_onehot(grant_onehot), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    typedef struct packed {
        logic [1:0]  port;
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic [1:0]  port;
        logic [31:0] data;
    } rbeat_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_unexp = 0;
    int          n_excl = 0;
    int          cyc = 0;
    beat_t       exp_q[$];
    rbeat_t      resp_q[$];
    int          hs_cyc[$];
    logic [32:0] pq[NP][$];
    logic [NP-1:0] hs = '0;
    logic [NP-1:0] hold = '0;
    int          beats_seen[NP];
    logic [32:0] fb;
    beat_t       eb;
    rbeat_t      rb;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_data(input int p, input int id, input int b);
        return {8'(p), 8'(id), 16'(b)};
    endfunction

    task automatic send_pkt(input int p, input int n, input int id);
        for (int b = 0; b < n; b++) begin
            pq[p].push_back({mk_data(p, id, b), (b == n - 1)});
        end
    endtask

    task automatic expect_pkt(input int p, input int n, input int id);
        beat_t e;
        for (int b = 0; b < n; b++) begin
            e.port = 2'(p);
            e.data = mk_data(p, id, b);
            e.last = (b == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || resp_q.size() > 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #1;
        chk_eq(tag, 64'(exp_q.size() + resp_q.size()), 64'd0);
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

    // Per-port source model: presents the head of each port queue, advances on handshake.
    initial begin
        s_req_tvalid = '0;
        s_req_tlast  = '0;
        s_req_tdata  = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int p = 0; p < NP; p++) begin
                if (hs[p] && pq[p].size() > 0) begin
                    void'(pq[p].pop_front());
                end
                if (pq[p].size() > 0 && !hold[p]) begin
                    fb = pq[p][0];
                    s_req_tvalid[p]          = 1'b1;
                    s_req_tdata[p*DW +: DW]  = fb[32:1];
                    s_req_tlast[p]           = fb[0];
                end else begin
                    s_req_tvalid[p] = 1'b0;
                    s_req_tlast[p]  = 1'b0;
                end
            end
        end
    end

    // Monitor: samples at negedge the handshakes that complete on the next rising edge.
    initial forever begin
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            hs[p] = s_req_tvalid[p] && s_req_tready[p];
            if (hs[p]) beats_seen[p]++;
            if (s_req_tready[p] && !grant_onehot[p]) n_excl++;
        end
        if (m_req_tvalid && m_req_tready) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_unexp++;
            end else begin
                eb = exp_q.pop_front();
                chk_eq("req_data",  64'(m_req_tdata), 64'(eb.data));
                chk_eq("req_last",  64'(m_req_tlast), 64'(eb.last));
                chk_eq("req_src",   64'(m_req_src),   64'(8'hA0 + 8'(eb.port)));
                chk_eq("req_dst",   64'(m_req_dst),   64'(8'hB0 + 8'(eb.port)));
                chk_eq("req_keep",  64'(m_req_tkeep), 64'(4'(eb.port) + 4'd1));
                chk_eq("req_grant", 64'(grant_onehot), 64'(4'b0001 << eb.port));
            end
        end
        for (int i = 0; i < NP; i++) begin
            if (s_resp_tvalid[i] && s_resp_tready[i]) begin
                if (resp_q.size() == 0) begin
                    n_unexp++;
                end else begin
                    rb = resp_q.pop_front();
                    chk_eq("resp_port", 64'(i), 64'(rb.port));
                    chk_eq("resp_data", 64'(s_resp_tdata[i*DW +: DW]), 64'(rb.data));
                end
            end
        end
    end

    initial begin
        int base;
        int n;
        rbeat_t r;
        rstn          = 1'b0;
        m_req_tready  = 1'b0;
        m_resp_tdata  = '0;
        m_resp_tkeep  = '0;
        m_resp_tstrb  = '0;
        m_resp_tlast  = 1'b0;
        m_resp_src    = '0;
        m_resp_dst    = '0;
        m_resp_tvalid = 1'b0;
        s_resp_tready = '0;
        for (int p = 0; p < NP; p++) begin
            s_req_src[p*8 +: 8]   = 8'hA0 + 8'(p);
            s_req_dst[p*8 +: 8]   = 8'hB0 + 8'(p);
            s_req_tkeep[p*KW +: KW] = 4'(p + 1);
            s_req_tstrb[p*KW +: KW] = 4'hF;
            beats_seen[p] = 0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_grant",    64'(grant_onehot), 64'd0);
        chk_eq("rst_pkt_cnt",  64'(pkt_cnt), 64'd0);
        chk_eq("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk_eq("rst_m_tvalid", 64'(m_req_tvalid), 64'd0);
        chk_eq("rst_s_tready", 64'(s_req_tready), 64'd0);
        chk_eq("rst_resp_rdy", 64'(m_resp_tready), 64'd1);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Round-robin over four single-flit requesters
        @(posedge clk); #1;
        m_req_tready = 1'b1;
        hs_cyc.delete();
        for (int p = 0; p < NP; p++) send_pkt(p, 1, 1);
        send_pkt(0, 1, 2);
        for (int p = 0; p < NP; p++) expect_pkt(p, 1, 1);
        expect_pkt(0, 1, 2);
        drain("rr_drain");
        chk_eq("rr_pkt_cnt", 64'(pkt_cnt), 64'd5);
        chk_eq("rr_hs_count", 64'(hs_cyc.size()), 64'd5);
        for (int i = 1; i < 5 && i < hs_cyc.size(); i++) begin
            chk_eq("rr_arb_gap", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd2);
        end

        // Port 0 requests while port 2 is mid-packet
        @(posedge clk); #1;
        base = beats_seen[2];
        send_pkt(2, 4, 3);
        expect_pkt(2, 4, 3);
        expect_pkt(0, 1, 3);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (beats_seen[2] == base && n < 50);
        chk_eq("lock_wait", 64'(beats_seen[2] - base), 64'd1);
        @(posedge clk); #1;
        send_pkt(0, 1, 3);
        repeat (2) begin
            @(negedge clk);
            chk_eq("lock_p0_rdy", 64'(s_req_tready[0]), 64'd0);
            chk_eq("lock_grant",  64'(grant_onehot), 64'b0100);
        end
        drain("lock_drain");
        chk_eq("lock_pkt_cnt", 64'(pkt_cnt), 64'd7);

        // Granted port 1 stalls for three cycles mid-packet
        @(posedge clk); #1;
        base = beats_seen[1];
        send_pkt(1, 3, 4);
        expect_pkt(1, 3, 4);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (beats_seen[1] == base && n < 50);
        hold[1] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_eq("stall_grant",  64'(grant_onehot), 64'b0010);
            chk_eq("stall_tvalid", 64'(m_req_tvalid), 64'd0);
        end
        #1;
        hold[1] = 1'b0;
        drain("stall_drain");

        // Response to port 2 with backpressure, request traffic in parallel
        @(posedge clk); #1;
        send_pkt(3, 2, 5);
        expect_pkt(3, 2, 5);
        m_resp_tvalid = 1'b1;
        m_resp_dst    = 8'h12;
        m_resp_tdata  = 32'hC0DE_0012;
        m_resp_tlast  = 1'b1;
        s_resp_tready = 4'b0000;
        r.port = 2'd2;
        r.data = 32'hC0DE_0012;
        resp_q.push_back(r);
        repeat (2) begin
            @(negedge clk);
            chk_eq("resp_tvalid", 64'(s_resp_tvalid), 64'b0100);
            chk_eq("resp_stall",  64'(m_resp_tready), 64'd0);
            chk_eq("resp_tlast",  64'(s_resp_tlast), 64'b1111);
            @(posedge clk); #1;
        end
        s_resp_tready = 4'b0100;
        @(negedge clk);
        chk_eq("resp_go", 64'(m_resp_tready), 64'd1);
        @(posedge clk); #1;
        m_resp_tvalid = 1'b0;
        s_resp_tready = 4'b0000;
        drain("resp_drain");

        // Unknown destination: three dropped beats
        @(posedge clk); #1;
        m_resp_dst    = 8'h55;
        m_resp_tvalid = 1'b1;
        s_resp_tready = 4'b1111;
        repeat (3) begin
            @(negedge clk);
            chk_eq("drop_tvalid", 64'(s_resp_tvalid), 64'd0);
            chk_eq("drop_ready",  64'(m_resp_tready), 64'd1);
            @(posedge clk); #1;
        end
        m_resp_tvalid = 1'b0;
        @(negedge clk);
        chk_eq("drop_cnt", 64'(drop_cnt), 64'd3);

        // Reset while locked on port 3
        @(posedge clk); #1;
        m_req_tready = 1'b0;
        send_pkt(3, 4, 6);
        n = 0;
        do begin @(negedge clk); n++; end while (grant_onehot != 4'b1000 && n < 50);
        chk_eq("rstlk_grant", 64'(grant_onehot), 64'b1000);
        @(posedge clk); #1;
        rstn = 1'b0;
        for (int p = 0; p < NP; p++) pq[p].delete();
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        chk_eq("rstlk_grant0",  64'(grant_onehot), 64'd0);
        chk_eq("rstlk_pkt_cnt", 64'(pkt_cnt), 64'd0);
        chk_eq("rstlk_drop",    64'(drop_cnt), 64'd0);
        chk_eq("rstlk_tvalid",  64'(m_req_tvalid), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        m_req_tready = 1'b1;
        send_pkt(3, 1, 7);
        send_pkt(1, 1, 7);
        expect_pkt(1, 1, 7);
        expect_pkt(3, 1, 7);
        @(negedge clk);
        chk_eq("post_rst_arb", 64'(m_req_tvalid), 64'd0);
        drain("post_rst_drain");
        chk_eq("post_rst_pkt", 64'(pkt_cnt), 64'd2);

        chk_eq("tready_excl", 64'(n_excl), 64'd0);
        chk_eq("unexpected_beats", 64'(n_unexp), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
